// File: rtl/btn_evt_pkg.sv
// ---------------------------------------------------------------------------
// btn_evt_pkg : shared types and sizing helpers for button_event_decoder
// Revision    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package btn_evt_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESS1 = 3'd1,
    GAP    = 3'd2,
    PRESS2 = 3'd3,
    LONG   = 3'd4
  } state_e;

  // Counter width sized to the largest interval; never narrower than one bit.
  function automatic int cnt_width(input int long_cyc, input int dclick_cyc,
                                   input int repeat_cyc);
    int m;
    m = long_cyc;
    if (dclick_cyc > m) m = dclick_cyc;
    if (repeat_cyc > m) m = repeat_cyc;
    if (m < 2) return 1;
    return $clog2(m);
  endfunction

endpackage

`default_nettype wire

// File: rtl/button_event_decoder_evt_timer.sv
// ---------------------------------------------------------------------------
// evt_timer : clearable saturating up-counter with compare-equal terminal hit
// Revision  : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module evt_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic [W-1:0] term,
  output logic         hit
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (cnt_q != {W{1'b1}}) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign hit = (cnt_q == term);

endmodule

`default_nettype wire

// File: rtl/button_event_decoder.sv
// ---------------------------------------------------------------------------
// button_event_decoder : classifies a debounced button level into
//                        short / double / long / auto-repeat event pulses
// Revision             : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module button_event_decoder
  import btn_evt_pkg::*;
#(
  parameter int LONG_CYC   = 50_000_000,
  parameter int DCLICK_CYC = 12_500_000,
  parameter int REPEAT_CYC = 10_000_000,
  parameter int REPEAT_EN  = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic db,
  output logic short_p,
  output logic double_p,
  output logic long_p,
  output logic rep_p,
  output logic held
);

  localparam int CNT_W = cnt_width(LONG_CYC, DCLICK_CYC, REPEAT_CYC);

  // The counter reads 0 on the first sample after a state change. The press
  // entry sample already counts as high sample 1, the release sample does not
  // count as a gap sample, and repeats are measured from the long_p edge.
  localparam logic [CNT_W-1:0] LONG_TERM = CNT_W'(LONG_CYC - 2);
  localparam logic [CNT_W-1:0] GAP_TERM  = CNT_W'(DCLICK_CYC - 1);
  localparam logic [CNT_W-1:0] REP_TERM  = CNT_W'(REPEAT_CYC - 1);

  state_e state_q, state_d;
  logic short_q, short_d;
  logic double_q, double_d;
  logic long_q, long_d;
  logic rep_q, rep_d;
  logic held_q, held_d;

  logic             tmr_clr;
  logic             tmr_hit;
  logic [CNT_W-1:0] tmr_term;

  evt_timer #(
    .W(CNT_W)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (tmr_clr),
    .term (tmr_term),
    .hit  (tmr_hit)
  );

  always_comb begin
    state_d  = state_q;
    short_d  = 1'b0;
    double_d = 1'b0;
    long_d   = 1'b0;
    rep_d    = 1'b0;
    tmr_term = LONG_TERM;

    case (state_q)
      IDLE: begin
        if (db) state_d = PRESS1;
      end
      PRESS1: begin
        if (!db) begin
          state_d = GAP;
        end else if (tmr_hit) begin
          state_d = LONG;
          long_d  = 1'b1;
        end
      end
      GAP: begin
        tmr_term = GAP_TERM;
        // A press on the expiring sample still wins as a double-click start.
        if (db) begin
          state_d = PRESS2;
        end else if (tmr_hit) begin
          state_d = IDLE;
          short_d = 1'b1;
        end
      end
      PRESS2: begin
        if (!db) begin
          state_d  = IDLE;
          double_d = 1'b1;
        end
      end
      LONG: begin
        tmr_term = REP_TERM;
        if (!db) begin
          state_d = IDLE;
        end else if ((REPEAT_EN != 0) && tmr_hit) begin
          rep_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    tmr_clr = (state_d != state_q) || rep_d;
    held_d  = (state_d == LONG);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      short_q  <= 1'b0;
      double_q <= 1'b0;
      long_q   <= 1'b0;
      rep_q    <= 1'b0;
      held_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      short_q  <= short_d;
      double_q <= double_d;
      long_q   <= long_d;
      rep_q    <= rep_d;
      held_q   <= held_d;
    end
  end

  assign short_p  = short_q;
  assign double_p = double_q;
  assign long_p   = long_q;
  assign rep_p    = rep_q;
  assign held     = held_q;

endmodule

`default_nettype wire

// File: tb/tb_button_event_decoder.sv
// ---------------------------------------------------------------------------
// tb_button_event_decoder : directed and pseudo-random checks of the decoder
// Revision                : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_button_event_decoder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic db  = 1'b0;

  logic s0, d0, l0, r0, h0;
  logic s1, d1, l1, r1, h1;
  logic [9:0] obs;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  button_event_decoder #(
    .LONG_CYC(8), .DCLICK_CYC(4), .REPEAT_CYC(3), .REPEAT_EN(1)
  ) dut0 (
    .clk(clk), .rst(rst), .db(db),
    .short_p(s0), .double_p(d0), .long_p(l0), .rep_p(r0), .held(h0)
  );

  button_event_decoder #(
    .LONG_CYC(8), .DCLICK_CYC(4), .REPEAT_CYC(3), .REPEAT_EN(0)
  ) dut1 (
    .clk(clk), .rst(rst), .db(db),
    .short_p(s1), .double_p(d1), .long_p(l1), .rep_p(r1), .held(h1)
  );

  // Vector layout per instance: {short, double, long, rep, held}.
  assign obs = {s0, d0, l0, r0, h0, s1, d1, l1, r1, h1};

  // Expected pair: the REPEAT_EN=0 instance never shows rep_p.
  function automatic logic [9:0] both(input logic [4:0] e);
    return {e, e & 5'b11101};
  endfunction

  task automatic step(input logic d);
    db = d;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    rst = 1'b1;
    step(1'b0);
    step(1'b0);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step(k[0]);
      checks++;
      if (obs !== 10'b0) begin
        failures++;
        $display("FAIL reset cycle %0d: got %b expected %b", k, obs, 10'b0);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_short_press;
    logic [9:0] exp;
    apply_reset;
    // Release sampled at edge 4, gap samples 5..8, short_p after edge 8.
    for (int k = 1; k <= 10; k++) begin
      step(k <= 3);
      exp = both({(k == 8), 4'b0000});
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL short_press cycle %0d: got %b expected %b", k, obs, exp);
      end
    end
  endtask

  task automatic test_double_click;
    logic [0:14] pat;
    logic [9:0]  exp;
    apply_reset;
    pat = 15'b110011000000000;
    for (int k = 1; k <= 12; k++) begin
      step(pat[k-1]);
      exp = both({1'b0, (k == 7), 3'b000});
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL double_click cycle %0d: got %b expected %b", k, obs, exp);
      end
    end
    // Press lands on the 4th gap sample: double click, no short.
    apply_reset;
    pat = 15'b110000100000000;
    for (int k = 1; k <= 12; k++) begin
      step(pat[k-1]);
      exp = both({1'b0, (k == 8), 3'b000});
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL dclick_edge cycle %0d: got %b expected %b", k, obs, exp);
      end
    end
    // Four full low gap samples: short, then the next press is a fresh one.
    apply_reset;
    pat = 15'b110000011000000;
    for (int k = 1; k <= 15; k++) begin
      step(pat[k-1]);
      exp = both({(k == 7 || k == 14), 4'b0000});
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL gap_expire cycle %0d: got %b expected %b", k, obs, exp);
      end
    end
  endtask

  task automatic test_long_repeat;
    logic [9:0] exp;
    apply_reset;
    for (int k = 1; k <= 22; k++) begin
      step(k <= 16);
      exp = both({2'b00, (k == 8), (k == 11 || k == 14), (k >= 8 && k <= 16)});
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL long_repeat cycle %0d: got %b expected %b", k, obs, exp);
      end
    end
  endtask

  task automatic test_boundary;
    logic [9:0] exp;
    apply_reset;
    // Seven highs fall one short of a long press.
    for (int k = 1; k <= 14; k++) begin
      step(k <= 7);
      exp = both({(k == 12), 4'b0000});
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL boundary7 cycle %0d: got %b expected %b", k, obs, exp);
      end
    end
  endtask

  task automatic test_reset_mid_gesture;
    logic [9:0] exp;
    apply_reset;
    step(1'b1);
    step(1'b1);
    step(1'b0);
    step(1'b0);
    rst = 1'b1;
    step(1'b0);
    rst = 1'b0;
    checks++;
    if (obs !== 10'b0) begin
      failures++;
      $display("FAIL reset_in_gap: got %b expected %b", obs, 10'b0);
    end
    for (int k = 1; k <= 7; k++) begin
      step(1'b0);
      checks++;
      if (obs !== 10'b0) begin
        failures++;
        $display("FAIL after_gap_reset cycle %0d: got %b expected %b", k, obs, 10'b0);
      end
    end
    // Button held through reset: a new press starts on the first free sample.
    rst = 1'b1;
    step(1'b1);
    rst = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      step(k <= 9);
      exp = both({2'b00, (k == 8), 1'b0, (k == 8 || k == 9)});
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL held_thru_reset cycle %0d: got %b expected %b", k, obs, exp);
      end
    end
  endtask

  task automatic test_random;
    logic [15:0] lfsr;
    logic        d;
    logic [4:0]  e;
    int          st;
    int          run;
    int          rc;
    lfsr = 16'hACE1;
    d    = 1'b0;
    st   = 0;
    run  = 0;
    rc   = 0;
    apply_reset;
    for (int k = 0; k < 1000; k++) begin
      lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      if (lfsr[2:0] == 3'd0) d = ~d;
      step(d);
      e = 5'b00000;
      case (st)
        0: if (d) begin st = 1; run = 1; end
        1: begin
          if (!d) begin
            st  = 2;
            run = 0;
          end else begin
            run++;
            if (run == 8) begin st = 4; e[2] = 1'b1; rc = 0; end
          end
        end
        2: begin
          if (d) begin
            st = 3;
          end else begin
            run++;
            if (run == 4) begin st = 0; e[4] = 1'b1; end
          end
        end
        3: if (!d) begin st = 0; e[3] = 1'b1; end
        default: begin
          if (!d) begin
            st = 0;
          end else begin
            rc++;
            if (rc == 3) begin e[1] = 1'b1; rc = 0; end
          end
        end
      endcase
      e[0] = (st == 4);
      checks++;
      if ($countones(obs[9:6]) > 1) begin
        failures++;
        $display("FAIL exclusive cycle %0d: got %b expected at most one pulse", k, obs[9:6]);
      end
      checks++;
      if (obs !== both(e)) begin
        failures++;
        $display("FAIL random cycle %0d: got %b expected %b", k, obs, both(e));
      end
    end
  endtask

  initial begin
    test_reset;
    test_short_press;
    test_double_click;
    test_long_repeat;
    test_boundary;
    test_reset_mid_gesture;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
